sar_controller_sync: RTL and testbench
======================================

Name: sar_controller_sync

Overview:
- Clocked, parametrised successor to the asynchronous SAR controller. The controller runs on one system clock instead of self-timed comparator handshakes.
- Sequences sampling, DAC settling, comparator strobing and bit decisions for an NBITS-bit differential capacitive SAR ADC.
- Adds a configurable sampling window, settle delay, comparator timeout with error flag, and a valid/ready output register with overrun detection.
- Sits between the capacitor-DAC switch drivers / latched comparator and the digital back-end.

Parameters:
NBITS, 9, conversion resolution (bits); minimum 2
SAMP_CYC, 4, clock cycles SAMP is held high; minimum 1
SETTLE_CYC, 3, minimum DAC settle cycles before each comparator strobe; minimum 1
TMO_CYC, 8, cycles allowed for a comparator decision or comparator reset before timeout; minimum 4

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
START  in  1  conversion request; honoured only in IDLE
ERRCLR  in  1  clears TMOERR and OVR sticky flags
COMPOUT  in  1  latched comparator output, asynchronous to CLK
CPb  in  1  comparator pre-latch output P, asynchronous to CLK
CNb  in  1  comparator pre-latch output N, asynchronous to CLK
SAMP  out  1  sampling switch control, registered
COMPCLK  out  1  comparator strobe, registered
COMPCLKb  out  1  complement of COMPCLK, registered
S  out  NBITS  DAC switch control: trial word
Sb  out  NBITS  ~S
SR  out  NBITS  reference switch control
SRb  out  NBITS  ~SR
BUSY  out  1  high whenever state is not IDLE
EOC  out  1  one-cycle pulse when a result is transferred to DOUT
DOUT  out  NBITS  conversion result register
DVALID  out  1  DOUT holds an unconsumed result
DREADY  in  1  consumer accepts DOUT when DVALID and DREADY are both high
TMOERR  out  1  sticky: a comparator timeout occurred
OVR  out  1  sticky: a result overwrote an unconsumed DOUT

Behaviour:
- Reset and sync:
  - Reset is synchronous and active-high; one clock.
  - Reset values: state=IDLE; Code=0; Mask=MSB one-hot; all counters=0.
  - Output reset values: SAMP=0, COMPCLK=0, COMPCLKb=1, BUSY=0, EOC=0, DOUT=0, DVALID=0, TMOERR=0, OVR=0.
  - COMPOUT, CPb and CNb each pass through a 2-flop synchronizer. "dec" = synced CPb OR synced CNb.
  - RST mid-conversion aborts immediately to IDLE; the partial code is discarded.
- Switch outputs:
  - Trial T = Code | Mask.
  - In IDLE and SAMPLE: S=0, SR=0, Sb=all ones, SRb=all ones.
  - Otherwise: S=T, SR=~T, Sb=~T, SRb=T.
- States:
  - IDLE: START=1 -> SAMPLE; load Code=0 and Mask=1<<(NBITS-1).
  - SAMPLE: SAMP=1 for exactly SAMP_CYC cycles, then -> SETTLE.
  - SETTLE: COMPCLK=0. Exit to COMPARE once at least SETTLE_CYC cycles have elapsed AND dec=0. If dec is still 1 after TMO_CYC cycles, set TMOERR and proceed to COMPARE anyway.
  - COMPARE: COMPCLK=1. Exit to DECIDE on dec=1, capturing the synced COMPOUT. If there is no decision within TMO_CYC cycles, set TMOERR, capture COMPOUT=1, and go to DECIDE.
  - DECIDE (1 cycle): COMPCLK=0. If captured COMPOUT=0, Code|=Mask; else Code is unchanged. Then Mask>>=1. If the old Mask was the LSB -> XFER, else -> SETTLE.
  - XFER (1 cycle): DOUT<=Code; DVALID<=1; EOC=1; if DVALID=1 and DREADY=0 at this cycle, OVR<=1. Then -> IDLE.
- Timing:
  - COMPCLKb is always ~COMPCLK; both are registered, so there is no overlap.
  - Model: comparator decides within one cycle of the strobe and resets within one cycle of strobe removal; SETTLE_CYC>=3.
  - Under that model, COMPARE lasts 3 cycles, and EOC asserts exactly 1+SAMP_CYC+NBITS*(SETTLE_CYC+4) cycles after the START edge. Defaults give 68.
- Handshake and flags:
  - DVALID clears on any cycle where DVALID and DREADY are both high and XFER is not active.
  - XFER coinciding with an accept loads the new result, keeps DVALID=1 and does not set OVR.
  - START while BUSY is ignored.
  - START held high in IDLE starts back-to-back conversions (XFER->IDLE->SAMPLE).
  - ERRCLR clears the sticky flags. When ERRCLR and a new error event occur in the same cycle, the flag is set.

Test Plan:
- Reset mid-COMPARE: assert RST -> next cycle state=IDLE, COMPCLK=0, COMPCLKb=1, SAMP=0, BUSY=0, DVALID=0, S=0, Sb=all ones.
- Ideal comparator, COMPOUT=(T>VIN), VIN=0x155, defaults, DREADY=1 -> EOC pulse 68 cycles after START, DOUT=0x155. Repeat for VIN=0x000 and 0x1FF.
- Comparator never decides (CPb=CNb=0) -> TMOERR=1, DOUT=0x000, conversion still completes. ERRCLR -> TMOERR=0.
- DREADY=0 with START held high for two conversions (VIN 0x0AA then 0x123) -> DOUT=0x123, DVALID=1, OVR=1. Raise DREADY -> DVALID clears next cycle.
- START pulsed during SETTLE -> ignored; exactly one EOC.
- NBITS=4, SAMP_CYC=1, SETTLE_CYC=3, VIN=0xA -> EOC 30 cycles after START, DOUT=0xA, S sequence 8,C,A,B.

Source files
------------

// File: rtl/sar_controller_sync.sv
// sar_controller_sync
// Clocked sequencer for an NBITS-bit differential capacitive SAR ADC.
// Drives sampling, DAC settling, comparator strobes and bit decisions,
// watches the comparator for timeouts, and presents each result through
// a valid/ready output register with overrun detection.
module sar_controller_sync #(
  parameter int NBITS      = 9,
  parameter int SAMP_CYC   = 4,
  parameter int SETTLE_CYC = 3,
  parameter int TMO_CYC    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ERRCLR,
  input  logic             COMPOUT,
  input  logic             CPb,
  input  logic             CNb,
  output logic             SAMP,
  output logic             COMPCLK,
  output logic             COMPCLKb,
  output logic [NBITS-1:0] S,
  output logic [NBITS-1:0] Sb,
  output logic [NBITS-1:0] SR,
  output logic [NBITS-1:0] SRb,
  output logic             BUSY,
  output logic             EOC,
  output logic [NBITS-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             TMOERR,
  output logic             OVR
);

  // One shared counter serves the sample window, settle delay and timeouts,
  // so it is sized for the largest of the three.
  localparam int CMAX_A = (SAMP_CYC > SETTLE_CYC) ? SAMP_CYC : SETTLE_CYC;
  localparam int CMAX   = (CMAX_A > TMO_CYC) ? CMAX_A : TMO_CYC;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SAMP_LAST   = CW'(SAMP_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TMO_CYC - 1);

  localparam logic [NBITS-1:0] MASK_MSB = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DECIDE,
    ST_XFER
  } state_t;

  state_t           state_reg;
  logic [NBITS-1:0] code_reg;
  logic [NBITS-1:0] mask_reg;
  logic [CW-1:0]    cnt_reg;
  logic             cmp_bit_reg;
  logic             samp_reg;
  logic             compclk_reg;
  logic             compclkb_reg;
  logic             busy_reg;
  logic             eoc_reg;
  logic [NBITS-1:0] dout_reg;
  logic             dvalid_reg;
  logic             tmoerr_reg;
  logic             ovr_reg;

  // Comparator lines are asynchronous to CLK: bit 2 = COMPOUT, 1 = CPb, 0 = CNb.
  localparam int NSYNC = 3;
  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] sync_out;
  logic             compout_s;
  logic             dec;

  assign async_in = {COMPOUT, CPb, CNb};

  genvar gi;
  generate
    for (gi = 0; gi < NSYNC; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer for one comparator line
      always_ff @(posedge CLK) begin
        if (RST) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  assign compout_s = sync_out[2];
  // Either pre-latch output going high means the comparator has resolved.
  assign dec       = sync_out[1] | sync_out[0];

  // Switch drivers are decoded straight from registered state, so they only
  // change on clock edges. The DAC is parked during IDLE and SAMPLE.
  logic [NBITS-1:0] trial;
  logic             sw_on;

  assign trial = code_reg | mask_reg;
  assign sw_on = (state_reg != ST_IDLE) && (state_reg != ST_SAMPLE);
  assign S     = sw_on ? trial  : '0;
  assign SR    = sw_on ? ~trial : '0;
  assign Sb    = ~S;
  assign SRb   = ~SR;

  assign SAMP     = samp_reg;
  assign COMPCLK  = compclk_reg;
  assign COMPCLKb = compclkb_reg;
  assign BUSY     = busy_reg;
  assign EOC      = eoc_reg;
  assign DOUT     = dout_reg;
  assign DVALID   = dvalid_reg;
  assign TMOERR   = tmoerr_reg;
  assign OVR      = ovr_reg;

  // Conversion FSM with registered strobes, result register and sticky flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      code_reg     <= '0;
      mask_reg     <= MASK_MSB;
      cnt_reg      <= '0;
      cmp_bit_reg  <= 1'b0;
      samp_reg     <= 1'b0;
      compclk_reg  <= 1'b0;
      compclkb_reg <= 1'b1;
      busy_reg     <= 1'b0;
      eoc_reg      <= 1'b0;
      dout_reg     <= '0;
      dvalid_reg   <= 1'b0;
      tmoerr_reg   <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      eoc_reg <= 1'b0;

      // Clearing comes first so that an error event later in this block wins.
      if (ERRCLR) begin
        tmoerr_reg <= 1'b0;
        ovr_reg    <= 1'b0;
      end

      // Consumer accept; an XFER in the same cycle overrides this below.
      if (dvalid_reg && DREADY) begin
        dvalid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            state_reg <= ST_SAMPLE;
            code_reg  <= '0;
            mask_reg  <= MASK_MSB;
            cnt_reg   <= '0;
            samp_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (cnt_reg == SAMP_LAST) begin
            state_reg <= ST_SETTLE;
            cnt_reg   <= '0;
            samp_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_SETTLE: begin
          // Wait for the DAC to settle and for the comparator to have reset
          // from the previous strobe before strobing again.
          if ((cnt_reg >= SETTLE_LAST) && !dec) begin
            state_reg    <= ST_COMPARE;
            cnt_reg      <= '0;
            compclk_reg  <= 1'b1;
            compclkb_reg <= 1'b0;
          end else if (dec && (cnt_reg >= TMO_LAST)) begin
            // Comparator stuck in a decided state: flag it and carry on.
            tmoerr_reg   <= 1'b1;
            state_reg    <= ST_COMPARE;
            cnt_reg      <= '0;
            compclk_reg  <= 1'b1;
            compclkb_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_COMPARE: begin
          if (dec) begin
            cmp_bit_reg  <= compout_s;
            state_reg    <= ST_DECIDE;
            compclk_reg  <= 1'b0;
            compclkb_reg <= 1'b1;
          end else if (cnt_reg >= TMO_LAST) begin
            // No decision: treat as "trial too high" so the bit is dropped.
            tmoerr_reg   <= 1'b1;
            cmp_bit_reg  <= 1'b1;
            state_reg    <= ST_DECIDE;
            compclk_reg  <= 1'b0;
            compclkb_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_DECIDE: begin
          if (!cmp_bit_reg) begin
            code_reg <= code_reg | mask_reg;
          end
          mask_reg <= mask_reg >> 1;
          cnt_reg  <= '0;
          if (mask_reg[0]) begin
            state_reg <= ST_XFER;
          end else begin
            state_reg <= ST_SETTLE;
          end
        end

        ST_XFER: begin
          dout_reg   <= code_reg;
          dvalid_reg <= 1'b1;
          eoc_reg    <= 1'b1;
          if (dvalid_reg && !DREADY) begin
            ovr_reg <= 1'b1;
          end
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg    <= ST_IDLE;
          samp_reg     <= 1'b0;
          compclk_reg  <= 1'b0;
          compclkb_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_controller_sync.sv
// Testbench for sar_controller_sync: default-parameter instance plus a
// 4-bit instance, each with a behavioural comparator model.
module tb_sar_controller_sync;

  localparam int NB        = 9;
  localparam int SAMP_C    = 4;
  localparam int SETTLE_C  = 3;
  localparam int TMO_C     = 8;
  localparam int NB2       = 4;
  localparam int SAMP_C2   = 1;
  localparam int SETTLE_C2 = 3;
  localparam int LAT       = 1 + SAMP_C + NB * (SETTLE_C + 4);
  localparam int LAT_TMO   = 1 + SAMP_C + NB * (SETTLE_C + TMO_C + 1);
  localparam int LAT2      = 1 + SAMP_C2 + NB2 * (SETTLE_C2 + 4);

  logic CLK = 1'b0;
  logic RST, START, ERRCLR, DREADY;
  logic COMPOUT = 1'b0, CPb = 1'b0, CNb = 1'b0;
  logic SAMP, COMPCLK, COMPCLKb, BUSY, EOC, DVALID, TMOERR, OVR;
  logic [NB-1:0] S, Sb, SR, SRb, DOUT;

  logic START2;
  logic COMPOUT2 = 1'b0, CPb2 = 1'b0, CNb2 = 1'b0;
  logic SAMP2, COMPCLK2, COMPCLKb2, BUSY2, EOC2, DVALID2, TMOERR2, OVR2;
  logic [NB2-1:0] S2, Sb2, SR2, SRb2, DOUT2;

  logic [NB-1:0]  vin;
  logic [NB2-1:0] vin2;
  logic           dead;

  logic [NB-1:0]  exp_q[$];
  logic [NB2-1:0] exp2_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sar_controller_sync dut (
    .CLK(CLK), .RST(RST), .START(START), .ERRCLR(ERRCLR),
    .COMPOUT(COMPOUT), .CPb(CPb), .CNb(CNb),
    .SAMP(SAMP), .COMPCLK(COMPCLK), .COMPCLKb(COMPCLKb),
    .S(S), .Sb(Sb), .SR(SR), .SRb(SRb),
    .BUSY(BUSY), .EOC(EOC), .DOUT(DOUT), .DVALID(DVALID),
    .DREADY(DREADY), .TMOERR(TMOERR), .OVR(OVR)
  );

  sar_controller_sync #(
    .NBITS(NB2), .SAMP_CYC(SAMP_C2), .SETTLE_CYC(SETTLE_C2), .TMO_CYC(8)
  ) dut2 (
    .CLK(CLK), .RST(RST), .START(START2), .ERRCLR(ERRCLR),
    .COMPOUT(COMPOUT2), .CPb(CPb2), .CNb(CNb2),
    .SAMP(SAMP2), .COMPCLK(COMPCLK2), .COMPCLKb(COMPCLKb2),
    .S(S2), .Sb(Sb2), .SR(SR2), .SRb(SRb2),
    .BUSY(BUSY2), .EOC(EOC2), .DOUT(DOUT2), .DVALID(DVALID2),
    .DREADY(DREADY), .TMOERR(TMOERR2), .OVR(OVR2)
  );

  // Comparator model: resolves within one cycle of the strobe, resets
  // within one cycle of its removal. COMPOUT=1 means trial above input.
  always @(negedge CLK) begin
    if (COMPCLK && !dead) begin
      COMPOUT = (S > vin);
      CPb     = (S > vin);
      CNb     = !(S > vin);
    end else begin
      CPb = 1'b0;
      CNb = 1'b0;
      if (dead) COMPOUT = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (COMPCLK2) begin
      COMPOUT2 = (S2 > vin2);
      CPb2     = (S2 > vin2);
      CNb2     = !(S2 > vin2);
    end else begin
      CPb2 = 1'b0;
      CNb2 = 1'b0;
    end
  end

  // Pulse (or hold) START on the main instance and queue the expected result.
  task automatic start_conv(input logic [NB-1:0] v, input logic [NB-1:0] expd, input logic hold);
    vin = v;
    exp_q.push_back(expd);
    START = 1'b1;
    @(posedge CLK); #1;
    START = hold;
  endtask

  // Wait for EOC on the main instance; lat counts edges after the current one.
  task automatic wait_eoc(input int budget, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge CLK); #1;
      if (EOC) begin
        lat  = n;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; START2 = 1'b0; ERRCLR = 1'b0; DREADY = 1'b1;
    vin = '0; vin2 = '0; dead = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({SAMP, COMPCLK, COMPCLKb, BUSY, EOC, DVALID, TMOERR, OVR} !== 8'b0010_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00100000",
               {SAMP, COMPCLK, COMPCLKb, BUSY, EOC, DVALID, TMOERR, OVR});
    end
    checks++;
    if (DOUT !== '0) begin
      failures++;
      $display("FAIL reset_dout: got %h expected 000", DOUT);
    end
    checks++;
    if ({S, Sb, SR, SRb} !== {{NB{1'b0}}, {NB{1'b1}}, {NB{1'b0}}, {NB{1'b1}}}) begin
      failures++;
      $display("FAIL reset_switch: got S=%h Sb=%h SR=%h SRb=%h expected 000 1ff 000 1ff", S, Sb, SR, SRb);
    end
    $display("test_reset done");
  endtask

  task automatic test_ideal();
    logic [NB-1:0] vals[3];
    logic [NB-1:0] expd;
    int  lat;
    bit  seen;
    vals = '{9'h155, 9'h000, 9'h1FF};
    DREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_conv(vals[i], vals[i], 1'b0);
      wait_eoc(200, lat, seen);
      expd = exp_q.pop_front();
      checks++;
      if (!seen || lat != LAT) begin
        failures++;
        $display("FAIL ideal_latency: got seen=%0d lat=%0d expected lat=%0d", seen, lat, LAT);
      end
      checks++;
      if (DOUT !== expd || DVALID !== 1'b1) begin
        failures++;
        $display("FAIL ideal_dout: got DOUT=%h DVALID=%b expected DOUT=%h DVALID=1", DOUT, DVALID, expd);
      end
      @(posedge CLK); #1;
      checks++;
      if (EOC !== 1'b0 || DVALID !== 1'b0) begin
        failures++;
        $display("FAIL ideal_after: got EOC=%b DVALID=%b expected 0 0", EOC, DVALID);
      end
      $display("ideal conv vin=%h dout=%h lat=%0d", vals[i], expd, lat);
    end
  endtask

  task automatic test_timeout();
    logic [NB-1:0] expd;
    int  lat;
    bit  seen;
    dead = 1'b1;
    start_conv(9'h155, 9'h000, 1'b0);
    wait_eoc(400, lat, seen);
    expd = exp_q.pop_front();
    checks++;
    if (!seen || lat != LAT_TMO) begin
      failures++;
      $display("FAIL tmo_latency: got seen=%0d lat=%0d expected lat=%0d", seen, lat, LAT_TMO);
    end
    checks++;
    if (DOUT !== expd || TMOERR !== 1'b1) begin
      failures++;
      $display("FAIL tmo_result: got DOUT=%h TMOERR=%b expected DOUT=%h TMOERR=1", DOUT, TMOERR, expd);
    end
    dead = 1'b0;
    ERRCLR = 1'b1;
    @(posedge CLK); #1;
    ERRCLR = 1'b0;
    checks++;
    if (TMOERR !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear: got TMOERR=%b expected 0", TMOERR);
    end
    $display("timeout conv dout=%h lat=%0d", expd, lat);
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] expd;
    int  lat;
    bit  seen;
    DREADY = 1'b0;
    start_conv(9'h0AA, 9'h0AA, 1'b1);
    wait_eoc(200, lat, seen);
    expd = exp_q.pop_front();
    checks++;
    if (!seen || DOUT !== expd || DVALID !== 1'b1 || OVR !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got seen=%0d DOUT=%h DVALID=%b OVR=%b expected DOUT=%h DVALID=1 OVR=0",
               seen, DOUT, DVALID, OVR, expd);
    end
    vin = 9'h123;
    exp_q.push_back(9'h123);
    repeat (2) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: got BUSY=%b expected 1", BUSY);
    end
    START = 1'b0;
    wait_eoc(200, lat, seen);
    expd = exp_q.pop_front();
    checks++;
    if (!seen || lat != LAT - 1) begin
      failures++;
      $display("FAIL b2b_spacing: got seen=%0d lat=%0d expected lat=%0d", seen, lat, LAT - 1);
    end
    checks++;
    if (DOUT !== expd || DVALID !== 1'b1 || OVR !== 1'b1) begin
      failures++;
      $display("FAIL b2b_overrun: got DOUT=%h DVALID=%b OVR=%b expected DOUT=%h DVALID=1 OVR=1",
               DOUT, DVALID, OVR, expd);
    end
    DREADY = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (DVALID !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got DVALID=%b expected 0", DVALID);
    end
    ERRCLR = 1'b1;
    @(posedge CLK); #1;
    ERRCLR = 1'b0;
    checks++;
    if (OVR !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got OVR=%b expected 0", OVR);
    end
    $display("back_to_back conv dout=%h", expd);
  endtask

  task automatic test_start_ignored();
    logic [NB-1:0] expd;
    int  eocs;
    int  first_lat;
    DREADY = 1'b1;
    eocs = 0;
    first_lat = 0;
    start_conv(9'h0C3, 9'h0C3, 1'b0);
    expd = exp_q.pop_front();
    for (int n = 1; n <= 160; n++) begin
      if (n == 5) START = 1'b1;
      if (n == 6) START = 1'b0;
      @(posedge CLK); #1;
      if (EOC) begin
        eocs++;
        if (eocs == 1) begin
          first_lat = n;
          checks++;
          if (DOUT !== expd) begin
            failures++;
            $display("FAIL ignore_dout: got %h expected %h", DOUT, expd);
          end
        end
      end
    end
    checks++;
    if (eocs != 1 || first_lat != LAT || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start: got eocs=%0d lat=%0d BUSY=%b expected eocs=1 lat=%0d BUSY=0",
               eocs, first_lat, BUSY, LAT);
    end
    $display("start_ignored conv dout=%h eocs=%0d", expd, eocs);
  endtask

  task automatic test_reset_mid_compare();
    logic [NB-1:0] expd;
    int  lat;
    bit  seen;
    bit  hit;
    int  stray;
    DREADY = 1'b0;
    start_conv(9'h0F0, 9'h0F0, 1'b0);
    wait_eoc(200, lat, seen);
    expd = exp_q.pop_front();
    checks++;
    if (!seen || DOUT !== expd || DVALID !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got seen=%0d DOUT=%h DVALID=%b expected DOUT=%h DVALID=1",
               seen, DOUT, DVALID, expd);
    end
    vin = 9'h05A;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK); #1;
      if (COMPCLK) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL abort_reach_compare: got COMPCLK=0 expected 1 within 60 cycles");
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if ({SAMP, COMPCLK, COMPCLKb, BUSY, DVALID} !== 5'b00100) begin
      failures++;
      $display("FAIL abort_ctrl: got %b expected 00100", {SAMP, COMPCLK, COMPCLKb, BUSY, DVALID});
    end
    checks++;
    if (S !== '0 || Sb !== '1 || DOUT !== '0) begin
      failures++;
      $display("FAIL abort_data: got S=%h Sb=%h DOUT=%h expected 000 1ff 000", S, Sb, DOUT);
    end
    stray = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge CLK); #1;
      if (EOC || BUSY) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", stray);
    end
    DREADY = 1'b1;
    $display("reset_mid_compare done");
  endtask

  task automatic test_small();
    logic [NB2-1:0] s_seen[$];
    logic [NB2-1:0] exp_seq[4];
    logic [NB2-1:0] expd;
    logic           prev;
    int             lat;
    exp_seq = '{4'h8, 4'hC, 4'hA, 4'hB};
    vin2 = 4'hA;
    exp2_q.push_back(4'hA);
    prev = 1'b0;
    lat = 0;
    START2 = 1'b1;
    @(posedge CLK); #1;
    START2 = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      if (COMPCLK2 && !prev) s_seen.push_back(S2);
      prev = COMPCLK2;
      if (EOC2) begin
        lat = n;
        break;
      end
    end
    expd = exp2_q.pop_front();
    checks++;
    if (lat != LAT2) begin
      failures++;
      $display("FAIL small_latency: got %0d expected %0d", lat, LAT2);
    end
    checks++;
    if (DOUT2 !== expd) begin
      failures++;
      $display("FAIL small_dout: got %h expected %h", DOUT2, expd);
    end
    checks++;
    if (s_seen.size() != 4) begin
      failures++;
      $display("FAIL small_strobes: got %0d expected 4", s_seen.size());
    end
    for (int i = 0; i < 4 && i < s_seen.size(); i++) begin
      checks++;
      if (s_seen[i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL small_s_seq[%0d]: got %h expected %h", i, s_seen[i], exp_seq[i]);
      end
    end
    $display("small conv vin=%h dout=%h lat=%0d", vin2, expd, lat);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_timeout();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_compare();
    test_small();
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp2_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
